alarm_arbiter: RTL and testbench



---
 rtl/alarm_arbiter.sv | 147 ++++++++++++++
 tb/tb_alarm_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_arbiter.sv
// alarm_arbiter: shares one buzzer between NREQ alarm requesters. Fixed priority, index 0 wins.
// Optional macro ALARM_ARBITER_PREEMPT_EN lets a higher-priority event take over a ringing session.
module alarm_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned BEEP_ON  = 4,
    parameter int unsigned BEEP_OFF = 4,
    parameter int unsigned RING_LEN = 64,
    parameter int unsigned GAP_LEN  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            ack,
    input  logic            mute,
    output logic            alarm,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            timeout_pulse
);
    localparam int unsigned PERIOD = BEEP_ON + BEEP_OFF;
    localparam int unsigned RW     = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;
    localparam int unsigned PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned GW     = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RING, GAP} state_t;

    state_t          state, state_next;
    logic [NREQ-1:0] pending, pending_next;
    logic [NREQ-1:0] req_d;
    logic            ack_d;
    logic [RW-1:0]   ring_cnt, ring_next;
    logic [PW-1:0]   phase_cnt, phase_next;
    logic [GW-1:0]   gap_cnt, gap_next;
    logic [NREQ-1:0] grant_next;
    logic            alarm_next, busy_next, timeout_next;

    logic [NREQ-1:0] req_rise_c, cand_c, cand_first_c;
    logic            ack_rise_c;

    assign req_rise_c   = req & ~req_d;
    assign ack_rise_c   = ack & ~ack_d;
    assign cand_c       = pending | req_rise_c;
    assign cand_first_c = cand_c & (~cand_c + NREQ'(1));

`ifdef ALARM_ARBITER_PREEMPT_EN
    // Bits below the one-hot grant are exactly the higher-priority requesters.
    logic preempt_c;
    assign preempt_c = |(cand_c & (grant - NREQ'(1)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= '0;
            req_d         <= '0;
            ack_d         <= 1'b0;
            ring_cnt      <= '0;
            phase_cnt     <= '0;
            gap_cnt       <= '0;
            grant         <= '0;
            alarm         <= 1'b0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            pending       <= pending_next;
            req_d         <= req;
            ack_d         <= ack;
            ring_cnt      <= ring_next;
            phase_cnt     <= phase_next;
            gap_cnt       <= gap_next;
            grant         <= grant_next;
            alarm         <= alarm_next;
            busy          <= busy_next;
            timeout_pulse <= timeout_next;
        end
    end

    // Next-state and registered-output logic; timeout_pulse is high in the first GAP cycle.
    always_comb begin
        state_next   = state;
        pending_next = cand_c;
        ring_next    = ring_cnt;
        phase_next   = phase_cnt;
        gap_next     = gap_cnt;
        grant_next   = grant;
        alarm_next   = alarm;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                grant_next = '0;
                alarm_next = 1'b0;
                if (cand_c != '0) begin
                    state_next   = RING;
                    grant_next   = cand_first_c;
                    pending_next = cand_c & ~cand_first_c;
                    ring_next    = '0;
                    phase_next   = '0;
                    alarm_next   = ~mute;
                end
            end
            RING: begin
                ring_next  = (ring_cnt == RW'(RING_LEN - 1)) ? ring_cnt : ring_cnt + RW'(1);
                phase_next = (phase_cnt == PW'(PERIOD - 1)) ? '0 : phase_cnt + PW'(1);
                alarm_next = (32'(phase_next) < BEEP_ON) & ~mute;
                if (ack_rise_c) begin
                    state_next = GAP;
                    gap_next   = '0;
                    grant_next = '0;
                    alarm_next = 1'b0;
                end
`ifdef ALARM_ARBITER_PREEMPT_EN
                else if (preempt_c) begin
                    grant_next   = cand_first_c;
                    pending_next = (cand_c & ~cand_first_c) | grant;
                    ring_next    = '0;
                    phase_next   = '0;
                    alarm_next   = ~mute;
                end
`endif
                else if (ring_cnt == RW'(RING_LEN - 1)) begin
                    state_next   = GAP;
                    gap_next     = '0;
                    grant_next   = '0;
                    alarm_next   = 1'b0;
                    timeout_next = 1'b1;
                end
            end
            GAP: begin
                grant_next = '0;
                alarm_next = 1'b0;
                if (gap_cnt == GW'(GAP_LEN - 1)) begin
                    state_next = IDLE;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                alarm_next = 1'b0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end
endmodule

// File: tb/tb_alarm_arbiter.sv
// tb_alarm_arbiter: directed plus random stimulus against a session-level reference model.
module tb_alarm_arbiter;
    localparam int NREQ     = 3;
    localparam int BEEP_ON  = 4;
    localparam int BEEP_OFF = 4;
    localparam int RING_LEN = 64;
    localparam int GAP_LEN  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic            ack;
    logic            mute;
    logic            alarm;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the buzzer, how long it has rung, how much gap remains.
    int              owner;
    int              age;
    int              gap_left;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] prev_r;
    logic            prev_a;
    logic            mute_s;
    logic            exp_to;
    int              n_timeouts;

    alarm_arbiter #(
        .NREQ(NREQ), .BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF),
        .RING_LEN(RING_LEN), .GAP_LEN(GAP_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .mute(mute),
        .alarm(alarm), .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1; age = 0; gap_left = 0; pend = '0;
        prev_r = '0; prev_a = 1'b0; mute_s = 1'b0; exp_to = 1'b0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] rise;
        logic            arise;
        int              nw;
        rise   = req & ~prev_r;
        arise  = ack & ~prev_a;
        prev_r = req;
        prev_a = ack;
        exp_to = 1'b0;
        pend   = pend | rise;
        if (owner >= 0) begin
            nw = lowest(pend);
            if (arise) begin
                owner = -1; gap_left = GAP_LEN;
            end
`ifdef ALARM_ARBITER_PREEMPT_EN
            else if (nw >= 0 && nw < owner) begin
                pend[nw] = 1'b0; pend[owner] = 1'b1; owner = nw; age = 0;
            end
`endif
            else if (age == RING_LEN - 1) begin
                owner = -1; gap_left = GAP_LEN; exp_to = 1'b1; n_timeouts++;
            end else begin
                age++;
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end else begin
            nw = lowest(pend);
            if (nw >= 0) begin
                owner = nw; pend[nw] = 1'b0; age = 0;
            end
        end
        mute_s = mute;
    endtask

    task automatic check_outputs(input string tag);
        logic [NREQ-1:0] eg;
        logic            ea, eb;
        eg = (owner >= 0) ? NREQ'(1 << owner) : '0;
        ea = (owner >= 0) && ((age % (BEEP_ON + BEEP_OFF)) < BEEP_ON) && !mute_s;
        eb = (owner >= 0) || (gap_left > 0);
        n_checks++;
        assert (grant === eg) else begin
            n_fail++; $error("FAIL %s grant: observed %b expected %b", tag, grant, eg);
        end
        n_checks++;
        assert (alarm === ea) else begin
            n_fail++; $error("FAIL %s alarm: observed %b expected %b", tag, alarm, ea);
        end
        n_checks++;
        assert (busy === eb) else begin
            n_fail++; $error("FAIL %s busy: observed %b expected %b", tag, busy, eb);
        end
        n_checks++;
        assert (timeout_pulse === exp_to) else begin
            n_fail++; $error("FAIL %s timeout_pulse: observed %b expected %b", tag, timeout_pulse, exp_to);
        end
    endtask

    task automatic tick(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            check_outputs(tag);
        end
    endtask

    task automatic check_zero(input string tag);
        n_checks++;
        assert ({alarm, grant, busy, timeout_pulse} === '0) else begin
            n_fail++; $error("FAIL %s outputs: observed %b expected 0", tag, {alarm, grant, busy, timeout_pulse});
        end
    endtask

    initial begin
        int to_before;
        rst_n = 1'b0; req = '0; ack = 1'b0; mute = 1'b0;
        n_timeouts = 0;
        model_reset();
        #12;
        check_zero("reset");
        rst_n = 1'b1;

        // Single requester runs to timeout, then gap and idle.
        tick("idle", 9);
        to_before = n_timeouts;
        req = 3'b010;
        tick("t1_timeout", 80);
        n_checks++;
        assert (n_timeouts - to_before === 1) else begin
            n_fail++; $error("FAIL t1_count timeouts: observed %0d expected 1", n_timeouts - to_before);
        end
        req = '0;
        tick("t1_tail", 3);

        // Acknowledge mid-session; held ack starts nothing.
        req = 3'b001;
        tick("t2_ring", 20);
        ack = 1'b1;
        tick("t2_ack", 100);
        ack = 1'b0; req = '0;
        tick("t2_tail", 3);

        // Simultaneous events served by priority, held requests give one session each.
        req = 3'b101;
        tick("t3_prio", 10);
        ack = 1'b1;
        tick("t3_ack", 2);
        ack = 1'b0;
        tick("t3_held", 290);
        req = '0;
        tick("t3_tail", 4);

        // Muted session keeps its timing.
        mute = 1'b1; req = 3'b100;
        tick("t4_mute", 75);
        mute = 1'b0; req = '0;
        tick("t4_tail", 3);

        // Async reset mid-session with two pending events.
        req = 3'b001;
        tick("t5_a", 3);
        req = 3'b100;
        tick("t5_b", 3);
        req = 3'b101;
        tick("t5_c", 24);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        model_reset();
        req = '0;
        @(posedge clk);
        #1;
        check_zero("t5_hold");
        rst_n = 1'b1;
        tick("t5_idle", 10);

        // Higher-priority event during a low-priority session.
        req = 3'b100;
        tick("t6_low", 10);
        req = 3'b101;
        tick("t6_high", 20);
        ack = 1'b1;
        tick("t6_ack", 2);
        ack = 1'b0;
        tick("t6_rest", 150);
        req = '0;
        tick("t6_tail", 4);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(15) == 0) req[b] = ~req[b];
            if ($urandom_range(29) == 0) ack = ~ack;
            if ($urandom_range(19) == 0) mute = ~mute;
            tick("rand", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
